// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcode/func encodings, hazard FSM states and the
// opcode-known table used by the source-usage decode.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_STOP  = 6'd63;

    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_SRA   = 6'd3;

    // DRAIN lasts this many cycles before HALT
    localparam logic [1:0] DRAIN_LEN = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } hz_state_e;

    // Opcodes whose operand usage is known exactly. Anything else
    // (including byte/half stores) is assumed to read both rs and rt.
    function automatic logic op_known(input logic [5:0] op);
        case (op)
            6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
            6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15,
            6'd32, 6'd33, 6'd35, 6'd36, 6'd37, 6'd43, 6'd63: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational source-usage decode and RAW compare against EX/MEM writers.
// Build option HAZARD_FWD_EN: forwarding present, only load-use stalls.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic [5:0] id_opcode,
    input  logic [5:0] id_func,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_regwrite,
    input  logic       ex_mem2reg,
    input  logic [4:0] ex_wreg,
    input  logic       mem_regwrite,
    input  logic [4:0] mem_wreg,
    output logic       stall_req
);

`ifdef HAZARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic uses_rs, uses_rt;
    logic raw_ex, raw_mem;

    // Decide which source fields the ID instruction actually reads
    always_comb begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        if (id_opcode == OP_J || id_opcode == OP_JAL)
            uses_rs = 1'b0;
        if (id_opcode == OP_RTYPE &&
            (id_func == FN_SLL || id_func == FN_SRL || id_func == FN_SRA))
            uses_rs = 1'b0;
        if (op_known(id_opcode) &&
            !(id_opcode == OP_RTYPE || id_opcode == OP_BEQ ||
              id_opcode == OP_BNE   || id_opcode == OP_SW))
            uses_rt = 1'b0;
    end

    // r0 is hardwired, so a write to it is never a dependency
    assign raw_ex  = ex_regwrite & (ex_wreg != 5'd0) &
                     ((uses_rs & (ex_wreg == id_rs)) | (uses_rt & (ex_wreg == id_rt)));
    assign raw_mem = mem_regwrite & (mem_wreg != 5'd0) &
                     ((uses_rs & (mem_wreg == id_rs)) | (uses_rt & (mem_wreg == id_rt)));

    // With forwarding only a load in EX cannot be bypassed in time
    assign stall_req = FWD_EN ? (raw_ex & ex_mem2reg) : (raw_ex | raw_mem);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush generation, STOP drain FSM and a
// saturating stall-cycle counter. Build option HAZARD_FWD_EN selects the
// load-use-only stall policy inside hazard_detect.
module hazard_ctrl
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  id_opcode,
    input  logic [5:0]  id_func,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_regwrite,
    input  logic        ex_mem2reg,
    input  logic [4:0]  ex_wreg,
    input  logic        mem_regwrite,
    input  logic [4:0]  mem_wreg,
    input  logic        ex_branch_taken,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    hz_state_e   state_q, state_d;
    logic [1:0]  drain_cnt_q, drain_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall_req;
    logic        is_stop;

    hazard_detect u_detect (
        .id_opcode    (id_opcode),
        .id_func      (id_func),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_regwrite  (ex_regwrite),
        .ex_mem2reg   (ex_mem2reg),
        .ex_wreg      (ex_wreg),
        .mem_regwrite (mem_regwrite),
        .mem_wreg     (mem_wreg),
        .stall_req    (stall_req)
    );

    assign is_stop   = (id_opcode == OP_STOP);
    assign stall_cnt = stall_cnt_q;

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= 2'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next state: branch beats stall, stall beats STOP (STOP waits for its
    // operands like any other instruction)
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    state_d = ST_RUN;
                end else if (stall_req) begin
                    if (stall_cnt_q != 16'hFFFF)
                        stall_cnt_d = stall_cnt_q + 16'd1;
                end else if (is_stop) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LEN;
                end
            end
            ST_DRAIN: begin
                drain_cnt_d = (drain_cnt_q == 2'd0) ? 2'd0 : drain_cnt_q - 2'd1;
                if (drain_cnt_q <= 2'd1)
                    state_d = ST_HALT;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    // Outputs: default is "frozen with a bubble", RUN opens the pipe
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b1;
        halted     = 1'b0;
        if (rst) begin
            ifid_flush = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                    end else if (!(stall_req || is_stop)) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        idex_flush = 1'b0;
                    end
                end
                ST_HALT: halted = 1'b1;
                default: halted = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, directed multi-cycle sequences and a
// randomized run checked against a rule-level reference model.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [3:0] O_RUN = 4'b1100;  // {pc_en, ifid_en, ifid_flush, idex_flush}
    localparam logic [3:0] O_STL = 4'b0001;
    localparam logic [3:0] O_BR  = 4'b1111;
    localparam logic [3:0] O_RST = 4'b0011;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  id_opcode, id_func;
    logic [4:0]  id_rs, id_rt, ex_wreg, mem_wreg;
    logic        ex_regwrite, ex_mem2reg, mem_regwrite, ex_branch_taken;
    logic        pc_en, ifid_en, ifid_flush, idex_flush, halted;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [5:0] op, fn;
        logic [4:0] rs, rt;
        logic       exw, exm;
        logic [4:0] exr;
        logic       memw;
        logic [4:0] memr;
        logic       br;
    } in_t;

    typedef struct {
        string      name;
        in_t        i;
        logic [3:0] e_out;
        logic [15:0] e_cnt;
    } vec_t;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_opcode       (id_opcode),
        .id_func         (id_func),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .ex_regwrite     (ex_regwrite),
        .ex_mem2reg      (ex_mem2reg),
        .ex_wreg         (ex_wreg),
        .mem_regwrite    (mem_regwrite),
        .mem_wreg        (mem_wreg),
        .ex_branch_taken (ex_branch_taken),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .halted          (halted),
        .stall_cnt       (stall_cnt)
    );

    function automatic in_t mk(input int op, fn, rs, rt, exw, exm, exr, memw, memr, br);
        in_t r;
        r.op = 6'(op); r.fn = 6'(fn); r.rs = 5'(rs); r.rt = 5'(rt);
        r.exw = 1'(exw); r.exm = 1'(exm); r.exr = 5'(exr);
        r.memw = 1'(memw); r.memr = 5'(memr); r.br = 1'(br);
        return r;
    endfunction

    task automatic apply(input in_t i);
        id_opcode = i.op; id_func = i.fn; id_rs = i.rs; id_rt = i.rt;
        ex_regwrite = i.exw; ex_mem2reg = i.exm; ex_wreg = i.exr;
        mem_regwrite = i.memw; mem_wreg = i.memr; ex_branch_taken = i.br;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {pc_en, ifid_en, ifid_flush, idex_flush};
    endfunction

    // Idle instruction: add r1,r2,r3 with no producers anywhere
    function automatic in_t idle();
        return mk(0, 32, 2, 3, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        apply(idle());
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ---- reference model: operand usage straight from the ISA rules ----
    function automatic bit m_reads_rs(input logic [5:0] op, input logic [5:0] fn);
        if (op inside {6'd2, 6'd3}) return 1'b0;
        if (op == 6'd0 && fn inside {6'd0, 6'd2, 6'd3}) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_reads_rt(input logic [5:0] op);
        if (op inside {6'd0, 6'd4, 6'd5, 6'd43}) return 1'b1;
        if (op inside {6'd2, 6'd3, 6'd6, 6'd7, [6'd8:6'd15], 6'd32, 6'd33,
                       6'd35, 6'd36, 6'd37, 6'd63}) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_dep(input in_t i, input logic w, input logic [4:0] r);
        return w && r != 0 &&
               ((m_reads_rs(i.op, i.fn) && r == i.rs) || (m_reads_rt(i.op) && r == i.rt));
    endfunction

    function automatic bit m_stall(input in_t i);
        if (FWD) return m_dep(i, i.exw, i.exr) && i.exm;
        return m_dep(i, i.exw, i.exr) || m_dep(i, i.memw, i.memr);
    endfunction

    vec_t vecs[$];

    initial begin
        logic [3:0] nf;
        logic [15:0] nfc;
        nf  = FWD ? O_RUN : O_STL;
        nfc = FWD ? 16'd0 : 16'd1;

        vecs.push_back('{"add_clean",   mk(0, 32, 2, 3, 0, 0, 0, 0, 0, 0), O_RUN, 16'd0});
        vecs.push_back('{"load_use_rs", mk(0, 32, 5, 7, 1, 1, 5, 0, 0, 0), O_STL, 16'd1});
        vecs.push_back('{"alu_ex_rt",   mk(0, 34, 1, 3, 1, 0, 3, 0, 0, 0), nf, nfc});
        vecs.push_back('{"mem_rs",      mk(8, 0, 4, 9, 0, 0, 0, 1, 4, 0),  nf, nfc});
        vecs.push_back('{"r0_never",    mk(0, 0, 9, 0, 1, 1, 0, 1, 0, 0),  O_RUN, 16'd0});
        vecs.push_back('{"sll_no_rs",   mk(0, 0, 5, 6, 1, 1, 5, 0, 0, 0),  O_RUN, 16'd0});
        vecs.push_back('{"j_no_rs",     mk(2, 0, 5, 5, 1, 1, 5, 0, 0, 0),  O_RUN, 16'd0});
        vecs.push_back('{"addi_no_rt",  mk(8, 0, 1, 5, 1, 1, 5, 0, 0, 0),  O_RUN, 16'd0});
        vecs.push_back('{"unk_op_rt",   mk(50, 0, 1, 5, 1, 1, 5, 0, 0, 0), O_STL, 16'd1});
        vecs.push_back('{"sw_rt",       mk(43, 0, 1, 5, 1, 1, 5, 0, 0, 0), O_STL, 16'd1});
        vecs.push_back('{"br_override", mk(63, 0, 5, 0, 1, 1, 5, 0, 0, 1), O_BR, 16'd0});
        vecs.push_back('{"no_regwrite", mk(0, 32, 5, 5, 0, 1, 5, 0, 0, 0), O_RUN, 16'd0});
        vecs.push_back('{"beq_mem_rt",  mk(4, 0, 1, 6, 0, 0, 0, 1, 6, 0),  nf, nfc});
        vecs.push_back('{"stop_clean",  mk(63, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_STL, 16'd0});
        vecs.push_back('{"unk_func_rs", mk(0, 63, 7, 1, 1, 1, 7, 0, 0, 0), O_STL, 16'd1});

        // reset behaviour
        rst = 1'b1;
        apply(idle());
        #2;
        chk("rst_outs", 32'(outs()), 32'(O_RST));
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        chk("post_rst_outs", 32'(outs()), 32'(O_RUN));
        chk("post_rst_cnt", 32'(stall_cnt), 32'd0);
        chk("post_rst_halt", 32'(halted), 32'd0);

        // vector table, each from a fresh reset
        foreach (vecs[k]) begin
            do_reset();
            apply(vecs[k].i);
            #2;
            chk({vecs[k].name, "_out"}, 32'(outs()), 32'(vecs[k].e_out));
            @(posedge clk); #1;
            chk({vecs[k].name, "_cnt"}, 32'(stall_cnt), 32'(vecs[k].e_cnt));
        end

        // ALU producer marching EX -> MEM -> gone
        do_reset();
        apply(mk(0, 34, 1, 3, 1, 0, 3, 0, 0, 0));
        #2; chk("alu_seq_c1", 32'(outs()), 32'(FWD ? O_RUN : O_STL));
        @(posedge clk); #1;
        apply(mk(0, 34, 1, 3, 0, 0, 0, 1, 3, 0));
        #2; chk("alu_seq_c2", 32'(outs()), 32'(FWD ? O_RUN : O_STL));
        @(posedge clk); #1;
        apply(idle());
        #2; chk("alu_seq_c3", 32'(outs()), 32'(O_RUN));
        chk("alu_seq_cnt", 32'(stall_cnt), FWD ? 32'd0 : 32'd2);

        // load-use stall, then STOP drain with a branch ignored, then reset
        do_reset();
        apply(mk(0, 32, 5, 7, 1, 1, 5, 0, 0, 0));
        @(posedge clk); #1;
        apply(mk(63, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2; chk("stop_c0", 32'(outs()), 32'(O_STL));
        @(posedge clk); #1;
        apply(mk(0, 32, 2, 3, 0, 0, 0, 0, 0, 1));
        for (int c = 1; c <= 3; c++) begin
            #2;
            chk($sformatf("drain_c%0d_out", c), 32'(outs()), 32'(O_STL));
            chk($sformatf("drain_c%0d_halt", c), 32'(halted), 32'd0);
            @(posedge clk); #1;
        end
        #2;
        chk("halt_c4", 32'(halted), 32'd1);
        chk("halt_c4_out", 32'(outs()), 32'(O_STL));
        repeat (3) @(posedge clk);
        #1;
        chk("halt_stays", 32'(halted), 32'd1);
        chk("halt_cnt", 32'(stall_cnt), 32'd1);
        rst = 1'b1;
        #2; chk("rst_in_halt_out", 32'(outs()), 32'(O_RST));
        @(posedge clk); #1;
        rst = 1'b0;
        apply(idle());
        #2;
        chk("halt_rst_halted", 32'(halted), 32'd0);
        chk("halt_rst_cnt", 32'(stall_cnt), 32'd0);
        chk("halt_rst_out", 32'(outs()), 32'(O_RUN));

        // reset while draining returns to RUN
        apply(mk(63, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        apply(idle());
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #2; chk("drain_abort", 32'(outs()), 32'(O_RUN));

        // saturation
        do_reset();
        apply(mk(0, 32, 5, 7, 1, 1, 5, 0, 0, 0));
        repeat (65534) @(posedge clk);
        #1; chk("sat_fffe", 32'(stall_cnt), 32'hFFFE);
        @(posedge clk); #1;
        chk("sat_ffff", 32'(stall_cnt), 32'hFFFF);
        repeat (4465) @(posedge clk);
        #1; chk("sat_hold", 32'(stall_cnt), 32'hFFFF);

        // randomized run against the rule-level model
        do_reset();
        begin
            int m_cnt;
            int m_age;   // -1 while running, else cycles since STOP accepted
            m_cnt = 0;
            m_age = -1;
            for (int c = 0; c < 3000; c++) begin
                in_t r;
                logic [5:0] ops[13];
                logic [5:0] fns[7];
                logic [3:0] e_out;
                logic       e_halt;
                bit         stl;
                ops = '{6'd0, 6'd0, 6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd13,
                        6'd35, 6'd43, 6'd50, 6'd17};
                fns = '{6'd0, 6'd2, 6'd3, 6'd32, 6'd34, 6'd42, 6'd63};
                r.op   = ($urandom_range(0, 49) == 0) ? 6'd63 : ops[$urandom_range(0, 12)];
                r.fn   = fns[$urandom_range(0, 6)];
                r.rs   = 5'($urandom_range(0, 3));
                r.rt   = 5'($urandom_range(0, 3));
                r.exw  = 1'($urandom_range(0, 1));
                r.exm  = 1'($urandom_range(0, 1));
                r.exr  = 5'($urandom_range(0, 3));
                r.memw = 1'($urandom_range(0, 1));
                r.memr = 5'($urandom_range(0, 3));
                r.br   = ($urandom_range(0, 7) == 0);
                rst    = ($urandom_range(0, 24) == 0);
                apply(r);
                #2;
                stl    = m_stall(r);
                e_halt = 1'b0;
                if (rst)                         e_out = O_RST;
                else if (m_age < 0) begin
                    if (r.br)                    e_out = O_BR;
                    else if (stl || r.op == 63)  e_out = O_STL;
                    else                         e_out = O_RUN;
                end else begin
                    e_out  = O_STL;
                    e_halt = (m_age >= 4);
                end
                chk($sformatf("rnd%0d_out", c), {27'd0, outs(), halted}, {27'd0, e_out, e_halt});
                chk($sformatf("rnd%0d_cnt", c), 32'(stall_cnt), 32'(m_cnt));
                if (rst) begin
                    m_cnt = 0;
                    m_age = -1;
                end else if (m_age < 0) begin
                    if (!r.br && stl) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                    else if (!r.br && r.op == 63) m_age = 1;
                end else if (m_age < 4) begin
                    m_age++;
                end
                @(posedge clk); #1;
            end
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
